// File: rtl/lcd_st7920_pkg.sv
// ============================================================================
//  Module   : lcd_st7920_pkg
//  Purpose  : ST7920 opcode masks, bit positions and FSM state shared by RX/TX
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_st7920_pkg;

    localparam logic [7:0] FUNC_SET_MASK   = 8'hE0;
    localparam logic [7:0] FUNC_SET_VAL    = 8'h20;
    localparam logic [7:0] DISP_CTRL_MASK  = 8'hF8;
    localparam logic [7:0] DISP_CTRL_VAL   = 8'h08;
    localparam logic [7:0] GDRAM_ADDR_MASK = 8'h80;
    localparam logic [7:0] GDRAM_ADDR_VAL  = 8'h80;
    localparam logic [7:0] CMD_CLEAR       = 8'h01;

    localparam int BIT_DL = 4;
    localparam int BIT_RE = 2;
    localparam int BIT_G  = 1;
    localparam int BIT_D  = 2;

    localparam logic [7:0] CMD_BASIC_8BIT  = 8'h30;
    localparam logic [7:0] CMD_EXT_GRAPHIC = 8'h36;
    localparam logic [7:0] CMD_DISP_ON     = 8'h0C;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WAIT_H = 1'b1
    } gdram_state_e;

    function automatic logic cmd_match(input logic [7:0] dat,
                                       input logic [7:0] mask,
                                       input logic [7:0] val);
        return (dat & mask) == val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_st7920_rx_if.sv
// ============================================================================
//  Module   : lcd_st7920_rx_if
//  Purpose  : ST7920 host bus plus framebuffer/status outputs of the receiver
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface lcd_st7920_rx_if #(
    parameter int FB_ADDR_W = 10
);
    logic                 lcd_rs;
    logic                 lcd_rw;
    logic                 lcd_en;
    logic [7:0]           lcd_dat;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_wdata;
    logic                 mode_8bit;
    logic                 ext_mode;
    logic                 graphic_on;
    logic                 display_on;
    logic                 clear_pulse;
    logic                 proto_err;

    modport master (
        output lcd_rs, lcd_rw, lcd_en, lcd_dat,
        input  fb_we, fb_addr, fb_wdata, mode_8bit, ext_mode,
               graphic_on, display_on, clear_pulse, proto_err
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_en, lcd_dat,
        output fb_we, fb_addr, fb_wdata, mode_8bit, ext_mode,
               graphic_on, display_on, clear_pulse, proto_err
    );
endinterface

`default_nettype wire

// File: rtl/lcd_bus_sync.sv
// ============================================================================
//  Module   : lcd_bus_sync
//  Purpose  : Synchronizes the ST7920 bus and emits one event per en fall
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       en_i,
    input  wire logic       rs_i,
    input  wire logic       rw_i,
    input  wire logic [7:0] dat_i,
    output logic            evt_valid_o,
    output logic            evt_rs_o,
    output logic            evt_rw_o,
    output logic [7:0]      evt_dat_o
);

    logic [SYNC_STAGES-1:0]      en_sync_q;
    logic [SYNC_STAGES-1:0]      rs_sync_q;
    logic [SYNC_STAGES-1:0]      rw_sync_q;
    logic [SYNC_STAGES-1:0][7:0] dat_sync_q;
    logic                        en_prev_q;
    logic                        armed_q;
    logic                        evt_valid_q;
    logic                        evt_rs_q;
    logic                        evt_rw_q;
    logic [7:0]                  evt_dat_q;
    logic                        w_fall;

    // The en chain resets high and edges are only armed once en has been seen
    // low, so a strobe already in progress at reset release is discarded.
    assign w_fall = armed_q & en_prev_q & ~en_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_q   <= '1;
            rs_sync_q   <= '0;
            rw_sync_q   <= '0;
            dat_sync_q  <= '0;
            en_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_rs_q    <= 1'b0;
            evt_rw_q    <= 1'b0;
            evt_dat_q   <= 8'h00;
        end else begin
            en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], en_i};
            rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], rs_i};
            rw_sync_q   <= {rw_sync_q[SYNC_STAGES-2:0], rw_i};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], dat_i};
            en_prev_q   <= en_sync_q[SYNC_STAGES-1];
            armed_q     <= armed_q | ~en_sync_q[SYNC_STAGES-1];
            evt_valid_q <= w_fall;
            evt_rs_q    <= rs_sync_q[SYNC_STAGES-1];
            evt_rw_q    <= rw_sync_q[SYNC_STAGES-1];
            evt_dat_q   <= dat_sync_q[SYNC_STAGES-1];
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_rs_o    = evt_rs_q;
    assign evt_rw_o    = evt_rw_q;
    assign evt_dat_o   = evt_dat_q;

endmodule

`default_nettype wire

// File: rtl/lcd_st7920_rx.sv
// ============================================================================
//  Module   : lcd_st7920_rx
//  Purpose  : ST7920 command decoder, GDRAM address FSM and framebuffer writer
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_st7920_rx
    import lcd_st7920_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FB_ADDR_W   = 10
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    lcd_st7920_rx_if.slave bus
);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_WAIT_H = WAIT_H;

    logic       evt_valid;
    logic       evt_rs;
    logic       evt_rw;
    logic [7:0] evt_dat;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (bus.lcd_en),
        .rs_i        (bus.lcd_rs),
        .rw_i        (bus.lcd_rw),
        .dat_i       (bus.lcd_dat),
        .evt_valid_o (evt_valid),
        .evt_rs_o    (evt_rs),
        .evt_rw_o    (evt_rw),
        .evt_dat_o   (evt_dat)
    );

    logic [0:0]           state_q,   state_d;
    logic [5:0]           vy_q,      vy_d;
    logic [4:0]           y_q,       y_d;
    logic [3:0]           x_q,       x_d;
    logic                 bsel_q,    bsel_d;
    logic                 oor_q,     oor_d;
    logic                 mode_q,    mode_d;
    logic                 ext_q,     ext_d;
    logic                 g_q,       g_d;
    logic                 disp_q,    disp_d;
    logic                 we_q,      we_d;
    logic [FB_ADDR_W-1:0] addr_q,    addr_d;
    logic [7:0]           wdata_q,   wdata_d;
    logic                 clr_q,     clr_d;
    logic                 err_q,     err_d;
    logic                 w_is_gaddr;

    assign w_is_gaddr = ~evt_rw & ~evt_rs & ext_q &
                        cmd_match(evt_dat, GDRAM_ADDR_MASK, GDRAM_ADDR_VAL);

    always_comb begin
        state_d = state_q;
        vy_d    = vy_q;
        y_d     = y_q;
        x_d     = x_q;
        bsel_d  = bsel_q;
        oor_d   = oor_q;
        mode_d  = mode_q;
        ext_d   = ext_q;
        g_d     = g_q;
        disp_d  = disp_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        clr_d   = 1'b0;
        err_d   = 1'b0;

        if (evt_valid) begin
            // An unfinished vertical/horizontal pair is abandoned by any other event.
            if (state_q == ST_WAIT_H && !w_is_gaddr) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end

            if (evt_rw) begin
                err_d = 1'b1;
            end else if (!evt_rs) begin
                if (cmd_match(evt_dat, FUNC_SET_MASK, FUNC_SET_VAL)) begin
                    mode_d = evt_dat[BIT_DL];
                    ext_d  = evt_dat[BIT_RE];
                    if (ext_q) begin
                        g_d = evt_dat[BIT_G];
                    end
                end else if (!ext_q && evt_dat == CMD_CLEAR) begin
                    clr_d  = 1'b1;
                    x_d    = 4'd0;
                    y_d    = 5'd0;
                    bsel_d = 1'b0;
                end else if (!ext_q && cmd_match(evt_dat, DISP_CTRL_MASK, DISP_CTRL_VAL)) begin
                    disp_d = evt_dat[BIT_D];
                end else if (w_is_gaddr) begin
                    if (state_q == ST_IDLE) begin
                        vy_d    = evt_dat[5:0];
                        state_d = ST_WAIT_H;
                    end else begin
                        y_d     = vy_q[4:0];
                        x_d     = evt_dat[3:0];
                        bsel_d  = 1'b0;
                        state_d = ST_IDLE;
                        oor_d   = vy_q[5] | (|evt_dat[6:4]);
                        if (oor_d) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end else begin
                if (!g_q || oor_q) begin
                    err_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = FB_ADDR_W'({y_q, x_q, bsel_q});
                    wdata_d = evt_dat;
                    bsel_d  = ~bsel_q;
                    // Horizontal-only auto-increment: x wraps, y never moves.
                    if (bsel_q) begin
                        x_d = x_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vy_q    <= 6'd0;
            y_q     <= 5'd0;
            x_q     <= 4'd0;
            bsel_q  <= 1'b0;
            oor_q   <= 1'b0;
            mode_q  <= 1'b0;
            ext_q   <= 1'b0;
            g_q     <= 1'b0;
            disp_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vy_q    <= vy_d;
            y_q     <= y_d;
            x_q     <= x_d;
            bsel_q  <= bsel_d;
            oor_q   <= oor_d;
            mode_q  <= mode_d;
            ext_q   <= ext_d;
            g_q     <= g_d;
            disp_q  <= disp_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
        end
    end

    assign bus.fb_we       = we_q;
    assign bus.fb_addr     = addr_q;
    assign bus.fb_wdata    = wdata_q;
    assign bus.mode_8bit   = mode_q;
    assign bus.ext_mode    = ext_q;
    assign bus.graphic_on  = g_q;
    assign bus.display_on  = disp_q;
    assign bus.clear_pulse = clr_q;
    assign bus.proto_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_st7920_rx.sv
// ============================================================================
//  Module   : tb_lcd_st7920_rx
//  Purpose  : Directed ST7920 bus cycles against a scoreboard of output pulses
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_st7920_rx;

    localparam int SYNC_STAGES = 2;
    localparam int FB_ADDR_W   = 10;
    localparam int LAT         = SYNC_STAGES + 2;

    typedef struct {
        bit                   we;
        bit                   clr;
        bit                   err;
        logic [FB_ADDR_W-1:0] addr;
        logic [7:0]           data;
        int                   cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb_q[$];

    lcd_st7920_rx_if #(.FB_ADDR_W(FB_ADDR_W)) bus ();

    lcd_st7920_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FB_ADDR_W   (FB_ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_flags(input string name, input logic [3:0] req);
        check(name, {28'd0, bus.mode_8bit, bus.ext_mode, bus.graphic_on, bus.display_on},
              {28'd0, req});
    endtask

    // One complete host cycle; the expected pulse set is queued at the en fall.
    task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d,
                             input bit we, input bit clr, input bit err,
                             input logic [FB_ADDR_W-1:0] a);
        exp_t e;
        @(negedge clk);
        bus.lcd_rs  = rs;
        bus.lcd_rw  = rw;
        bus.lcd_dat = d;
        bus.lcd_en  = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_en = 1'b0;
        if (we || clr || err) begin
            e.we   = we;
            e.clr  = clr;
            e.err  = err;
            e.addr = a;
            e.data = d;
            e.cyc  = cyc + LAT;
            sb_q.push_back(e);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] d, input bit err);
        bus_cycle(1'b0, 1'b0, d, 1'b0, 1'b0, err, '0);
    endtask

    task automatic wr(input logic [7:0] d, input bit we, input bit err,
                      input logic [FB_ADDR_W-1:0] a);
        bus_cycle(1'b1, 1'b0, d, we, 1'b0, err, a);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n       = 1'b0;
        bus.lcd_en  = 1'b0;
        bus.lcd_rs  = 1'b0;
        bus.lcd_rw  = 1'b0;
        bus.lcd_dat = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (bus.fb_we || bus.clear_pulse || bus.proto_err) begin
                    tests++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_pulse: got we=%b clr=%b err=%b at cycle %0d, expected none",
                                 bus.fb_we, bus.clear_pulse, bus.proto_err, cyc);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (bus.fb_we !== e.we || bus.clear_pulse !== e.clr ||
                            bus.proto_err !== e.err || cyc != e.cyc ||
                            (e.we && (bus.fb_addr !== e.addr || bus.fb_wdata !== e.data))) begin
                            fails++;
                            $display("FAIL pulse: got we=%b clr=%b err=%b addr=0x%0h data=0x%0h cyc=%0d, expected we=%b clr=%b err=%b addr=0x%0h data=0x%0h cyc=%0d",
                                     bus.fb_we, bus.clear_pulse, bus.proto_err, bus.fb_addr,
                                     bus.fb_wdata, cyc, e.we, e.clr, e.err, e.addr, e.data, e.cyc);
                        end
                    end
                end
            end
        join_none

        repeat (4) @(negedge clk);
        check("reset_outputs", {19'd0, bus.fb_we, bus.fb_addr, bus.fb_wdata, bus.clear_pulse,
                                bus.proto_err}, 32'd0);
        check_flags("reset_flags", 4'b0000);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Init: DL, display on, RE, then G on the second 0x36
        cmd(8'h30, 1'b0); check_flags("init_30", 4'b1000);
        cmd(8'h0C, 1'b0); check_flags("init_0C", 4'b1001);
        cmd(8'h36, 1'b0); check_flags("init_36a", 4'b1101);
        cmd(8'h36, 1'b0); check_flags("init_36b", 4'b1111);

        cmd(8'h85, 1'b0);
        cmd(8'h83, 1'b0);
        wr(8'hAA, 1'b1, 1'b0, 10'h0A6);
        wr(8'h55, 1'b1, 1'b0, 10'h0A7);
        wr(8'h0F, 1'b1, 1'b0, 10'h0A8);

        // x wraps 15 -> 0 on the last row, y holds
        cmd(8'h9F, 1'b0);
        cmd(8'h8F, 1'b0);
        wr(8'h11, 1'b1, 1'b0, 10'h3FE);
        wr(8'h22, 1'b1, 1'b0, 10'h3FF);
        wr(8'h33, 1'b1, 1'b0, 10'h3E0);
        wr(8'h44, 1'b1, 1'b0, 10'h3E1);

        cmd(8'hA0, 1'b0);
        cmd(8'h80, 1'b1);
        wr(8'h77, 1'b0, 1'b1, '0);
        cmd(8'h81, 1'b0);
        cmd(8'h80, 1'b0);
        wr(8'h99, 1'b1, 1'b0, 10'h020);

        // Back to basic mode: G drops because RE was set before this function set
        cmd(8'h30, 1'b0); check_flags("basic_30", 4'b1001);
        bus_cycle(1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, '0);
        bus_cycle(1'b0, 1'b1, 8'h36, 1'b0, 1'b0, 1'b1, '0);
        check_flags("read_nochange", 4'b1001);
        cmd(8'h34, 1'b0); check_flags("ext_no_g", 4'b1101);
        cmd(8'h84, 1'b0);
        wr(8'h12, 1'b0, 1'b1, '0);
        check_flags("g_still_off", 4'b1101);

        // Reset during en high with a vertical address pending
        cmd(8'h88, 1'b0);
        @(negedge clk);
        bus.lcd_rs  = 1'b1;
        bus.lcd_rw  = 1'b0;
        bus.lcd_dat = 8'h5A;
        bus.lcd_en  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {19'd0, bus.fb_we, bus.fb_addr, bus.fb_wdata,
                                   bus.clear_pulse, bus.proto_err}, 32'd0);
        check_flags("midreset_flags", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_en = 1'b0;
        repeat (8) @(negedge clk);
        check_flags("after_abort", 4'b0000);

        // FSM must be back in IDLE: 0x83 starts a fresh pair
        cmd(8'h30, 1'b0);
        cmd(8'h36, 1'b0);
        cmd(8'h36, 1'b0); check_flags("reinit", 4'b1110);
        cmd(8'h83, 1'b0);
        cmd(8'h80, 1'b0);
        wr(8'hC3, 1'b1, 1'b0, 10'h060);

        repeat (6) @(negedge clk);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_pulse: got nothing, expected we=%b clr=%b err=%b at cycle %0d",
                     e.we, e.clr, e.err, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_st7920_rx.md
Name: lcd_st7920_rx

Overview:
- Synthesizable responder for the ST7920 8-bit parallel bus (rs/rw/en/dat) driven by our 128x64 LCD controller.
- Samples host bus cycles in the system clock domain and decodes basic- and extended-instruction commands.
- Tracks GDRAM vertical/horizontal address and auto-increment, and emits byte writes to a 1024-byte framebuffer.
- Used for on-FPGA loopback capture and as the checker-side model in controller benches.

Parameters:
- SYNC_STAGES, 2, flops in the lcd_en/rs/rw/dat synchronizer (min 2).
- FB_ADDR_W, 10, framebuffer byte-address width (32 rows x 16 words x 2 bytes).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- lcd_rs  in  1  0 = command, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_en  in  1  enable strobe; the bus is latched on its falling edge.
- lcd_dat  in  8  bus byte.
- fb_we  out  1  one-cycle framebuffer byte-write pulse.
- fb_addr  out  FB_ADDR_W  byte address = {y[4:0], x[3:0], byte_sel}.
- fb_wdata  out  8  byte to write.
- mode_8bit  out  1  DL bit from the last function set.
- ext_mode  out  1  RE bit (extended instruction set active).
- graphic_on  out  1  G bit.
- display_on  out  1  D bit from display control.
- clear_pulse  out  1  one-cycle pulse on a clear-display command.
- proto_err  out  1  one-cycle pulse on any protocol violation (see below).

Behaviour:
- lcd_en, lcd_rs, lcd_rw and lcd_dat all pass through an identical SYNC_STAGES pipeline.
  - A falling edge is detected on synced en (prev=1, cur=0).
  - The rs/rw/dat values sampled in the same synced cycle as the edge form the bus event.
- All outputs are registered.
  - fb_we, clear_pulse and proto_err assert exactly SYNC_STAGES+1 clk cycles after the first clk edge that samples lcd_en low at the pin.
  - Pulses last 1 cycle.
  - Hosts hold rs/dat stable across the whole en high phase plus SYNC_STAGES+1 clk cycles after the fall.
- Reset values (all async on rst_n low):
  - fb_we=0, fb_addr=0, fb_wdata=0, clear_pulse=0, proto_err=0.
  - mode_8bit=0, ext_mode=0, graphic_on=0, display_on=0.
  - Internal: state=IDLE, x=0, y=0, byte_sel=0, en_prev=0.
  - Reset mid-bus-cycle discards that cycle.
- rw=1 events: ignored; pulse proto_err. No bus drive; this block is input-only.
- Command decode (rs=0), priority top-down:
  - dat[7:5]=001 (function set):
    - mode_8bit<=dat[4]; ext_mode<=dat[2].
    - graphic_on<=dat[1] only if ext_mode was already 1 before this command. Hence 0x36 must be written twice from basic mode to set G.
  - ext_mode=0, dat=0x01: pulse clear_pulse; x, y, byte_sel <= 0.
  - ext_mode=0, dat[7:3]=00001: display_on<=dat[2].
  - ext_mode=1, dat[7]=1: GDRAM address; see the FSM below.
  - Anything else (including basic-mode DDRAM address 1xxxxxxx): no state change, no error.
- GDRAM address FSM, states IDLE and WAIT_H:
  - IDLE + extended address byte:
    - Latch vy <= dat[5:0] and go to WAIT_H.
  - WAIT_H + extended address byte:
    - y <= vy[4:0], x <= dat[3:0], byte_sel <= 0, go to IDLE.
    - If vy[5]=1 or dat[6:4]!=0: set the internal out_of_range flag and pulse proto_err. Otherwise clear out_of_range.
  - WAIT_H + any other event (data, non-address command, read):
    - Process that event normally, go to IDLE, pulse proto_err. The pending vertical address is discarded.
- Data write (rs=0 rw=0 excluded; i.e. rs=1, rw=0):
  - If graphic_on=0 or out_of_range=1: no write; pulse proto_err.
  - Otherwise:
    - fb_we=1, fb_addr={y,x,byte_sel}, fb_wdata=dat. byte_sel 0 is the high byte of the 16-bit word.
    - byte_sel toggles. On 1->0, x increments with wrap 15->0; y is unchanged (ST7920 horizontal-only auto-increment).
- Simultaneous events cannot occur: there is at most one en falling edge per SYNC_STAGES+1 cycles by the bus timing contract. A new edge arriving earlier is still processed in order; no event is dropped.

Decomposition:
- Shared package lcd_st7920_pkg:
  - Command opcode masks and values: FUNC_SET 001xxxxx, DISP_CTRL 00001xxx, CLEAR 0x01, GDRAM_ADDR 1xxxxxxx.
  - Bit positions DL=4, RE=2, G=1, D=2.
  - The 0x30, 0x36 and 0x0C constants, shared with the transmitter side.
  - The state enum {IDLE, WAIT_H}.
- One sub-module, lcd_bus_sync: parameterized synchronizer plus falling-edge detector. It outputs evt_valid, evt_rs, evt_rw and evt_dat. The decoder/FSM stays in the top module.

Test Plan:
- Init sequence 0x30, 0x0C, 0x36, 0x36 -> mode_8bit=1, display_on=1, ext_mode=1, graphic_on=1 after the 4th write only (0 after the 3rd); no proto_err.
- After init: addr 0x85, 0x83, then data 0xAA, 0x55, 0x0F -> fb_we x3 with (addr,data) = (0x0A6,0xAA), (0x0A7,0x55), (0x0A8,0x0F), each SYNC_STAGES+1 cycles after its en fall.
- Addr 0x9F, 0x8F, then 4 data bytes -> addresses 0x3FE, 0x3FF, 0x3E0, 0x3E1 (x wraps 15->0, y stays 31).
- Addr 0xA0, 0x80 (vy[5]=1) -> proto_err pulse; a following data write produces no fb_we and another proto_err. Then 0x81, 0x80 clears the flag and the next data write goes to 0x020.
- Basic mode 0x01 -> clear_pulse=1 for one cycle. rw=1 strobe -> proto_err, no other change. Vertical 0x84 followed by data -> proto_err; the data is rejected if graphic_on=0.
- Assert rst_n low during en high with a pending WAIT_H -> all outputs at reset values; the next falling edge after release is not produced from the aborted cycle.
